// File: rtl/fifo_serializer.sv
// Pulls 16-bit words from a synchronous FIFO read port and sends each one as a
// serial frame: start bit (0), 16 data bits MSB first, stop bit (1).
module fifo_serializer #(
  parameter int unsigned DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        EMPTY,
  input  logic        VALID,
  input  logic        UNDER,
  input  logic [15:0] DOUT,
  output logic        RD,
  output logic        TXD,
  output logic        BUSY,
  output logic        ERR,
  output logic [7:0]  SENT
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 4;
  localparam int unsigned WW = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] sent_q, sent_d;
  logic          rd_q, rd_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          last_tick;

  assign last_tick = (tick_q == TW'(DIV - 1));

  // Next-state logic; outputs are derived from the next state so they are
  // registered yet line up with the state they describe.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    wait_d  = wait_q;
    sent_d  = sent_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (EN && !EMPTY) state_d = S_REQ;
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (VALID) begin
          shift_d = DOUT;
          tick_d  = '0;
          state_d = S_START;
        end else if (UNDER || (wait_q == WW'(3))) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_START: begin
        if (last_tick) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DATA: begin
        if (last_tick) begin
          tick_d = '0;
          if (bit_q == BW'(DW - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q << 1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_STOP: begin
        if (last_tick) begin
          tick_d  = '0;
          sent_d  = sent_q + CW'(1);
          state_d = S_IDLE;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_d   = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[DW-1];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
      wait_q  <= '0;
      sent_q  <= '0;
      rd_q    <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      wait_q  <= wait_d;
      sent_q  <= sent_d;
      rd_q    <= rd_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign RD   = rd_q;
  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;
  assign SENT = sent_q;

endmodule
